tdc_multi_channel: RTL and testbench
====================================

Name: tdc_multi_channel

Overview:
- Parametrised multi-channel time-to-digital converter. Next generation of the single-channel start/stop TDC tile.
- Each channel synchronises its asynchronous start/stop pads, then counts clk cycles between the detected start and stop edges.
- Each channel latches its result with valid/overflow status; results are read out a byte at a time over an 8-bit port.
- Sits behind the tile top level: start/stop come from ui_in, readout drives uo_out, and channel/byte select comes from uio_in.

Parameters:
- NUM_CH, 2: number of independent channels (1..8).
- CNT_W, 16: counter/result width in bits; must be a multiple of 8 (8..32).
- SYNC_STAGES, 2: flip-flop stages in each start/stop synchroniser (>=2).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  NUM_CH  asynchronous per-channel start pulses.
- stop  in  NUM_CH  asynchronous per-channel stop pulses.
- rd_ch  in  CH_W  channel select for readout; CH_W = max(1, clog2(NUM_CH)).
- rd_byte  in  BY_W  byte select, 0 = LSB; BY_W = max(1, clog2(CNT_W/8)).
- rd_ack  in  1  one-cycle pulse: acknowledge and clear the selected channel.
- rd_data  out  8  registered byte of the selected result.
- valid  out  NUM_CH  per-channel result-ready flags.
- busy  out  NUM_CH  per-channel measurement-in-progress flags.
- ovf  out  NUM_CH  per-channel counter-saturated flags.

Behaviour:
- Reset: all synchroniser and edge-detect registers cleared. Every FSM goes to IDLE. count, result, valid, busy, ovf and rd_data all 0.
- Synchroniser: SYNC_STAGES flops per input, then an edge-detect flop. A rise = sync output 1 while the previous value was 0. Edge latency from pad to internal pulse is SYNC_STAGES+1 clk.
- Per-channel FSM states: IDLE, RUN, DONE.
  - IDLE, start rise: go to RUN, count=0, busy=1.
  - IDLE, start rise and stop rise in the same cycle: go to DONE, result=0, valid=1, busy stays 0.
  - IDLE, stop rise alone: ignored.
  - RUN: count increments by 1 every clk.
  - RUN, stop rise: result=count+1 (number of cycles from start-edge cycle to stop-edge cycle), go to DONE, valid=1, busy=0.
  - RUN, start rise: ignored; the first start wins.
  - RUN, count reaches 2^CNT_W-2 with no stop: on the next cycle result = all ones, ovf=1, valid=1, go to DONE. A stop in that same cycle also yields all ones with ovf=1.
  - DONE: start and stop edges are ignored (unless TDC_AUTO_REARM_EN is defined). Holds until rd_ack with rd_ch equal to this channel. Then go to IDLE and clear valid and ovf; result is held until overwritten.
- rd_ack with rd_ch selecting a channel not in DONE: no effect.
- rd_ack on the same cycle as a start rise on the acked channel: the ack is processed first and the start is lost. The channel returns to IDLE; it re-arms only on the next start edge.
- Readout: rd_data <= result[rd_ch][8*rd_byte +: 8] every cycle, 1-cycle latency.
  - rd_ch >= NUM_CH or rd_byte >= CNT_W/8: rd_data <= 0.
  - rd_data reflects the result register whatever the valid state.
- Channels are fully independent; simultaneous events on different channels have no interaction.
- Reset mid-measurement: the channel returns to IDLE on the next clk; the partial count is discarded.

Optional Feature:
- Macro: TDC_AUTO_REARM_EN.
- Defined:
  - A start rise while in DONE goes directly to RUN with count=0, busy=1. valid is cleared and sticky overrun bit ovr[ch] is set.
  - ovr is exposed as extra output port ovr[NUM_CH]. It is cleared only by rst or by rd_ack to that channel.
  - Start and stop rising together in DONE: result=0, valid=1, ovr=1, stay in DONE.
- Not defined: DONE ignores starts as above, and the ovr port does not exist.

Test Plan:
- Reset: rst high 2 clk -> valid=0, busy=0, ovf=0, rd_data=0 on all channels.
- Basic measure: NUM_CH=2, CNT_W=16; ch0 start pulse, stop pulse 100 clk later -> busy[0] high ~100 clk. Then valid[0]=1 and result 100. rd_byte=0 gives rd_data=0x64 next cycle; rd_byte=1 gives 0x00. rd_ack with rd_ch=0 -> valid[0]=0.
- Concurrent channels: ch0 interval 37, ch1 interval 1000 overlapping -> result0=37 (0x25,0x00) and result1=1000 (0xE8,0x03); ack of ch1 leaves valid[0]=1.
- Overflow: CNT_W=8, start with no stop -> after 255 clk valid=1, ovf=1, rd_data=0xFF; a later stop is ignored.
- Edge cases: start and stop rising together -> result 0, valid=1. Stop alone in IDLE -> no change. Second start in RUN -> result still measured from the first start. rd_ch=3 with NUM_CH=2 -> rd_data=0.
- Reset mid-run and rearm: rst during RUN at count 50 -> IDLE, busy=0. With TDC_AUTO_REARM_EN, a start in DONE -> ovr=1, valid=0, new measurement of 20 gives result 20.

Source files
------------

// File: rtl/tdc_multi_channel_if.sv
`default_nettype none
// ============================================================================
// Module      : tdc_multi_channel_if
// Description : Readout bus of the multi-channel TDC (channel/byte select,
//               acknowledge strobe, registered result byte).
// Revision    : 1.0 - initial release
// ============================================================================
interface tdc_multi_channel_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BY_W = ((CNT_W / 8) > 1) ? $clog2(CNT_W / 8) : 1;

    logic [CH_W-1:0] rd_ch;
    logic [BY_W-1:0] rd_byte;
    logic            rd_ack;
    logic [7:0]      rd_data;

    modport master (output rd_ch, output rd_byte, output rd_ack, input  rd_data);
    modport slave  (input  rd_ch, input  rd_byte, input  rd_ack, output rd_data);
endinterface
`default_nettype wire

// File: rtl/tdc_multi_channel.sv
`default_nettype none
// ============================================================================
// Module      : tdc_multi_channel
// Description : NUM_CH independent start/stop TDC channels with synchronisers,
//               saturating counters and byte-wide result readout.
//               Optional macro TDC_AUTO_REARM_EN: re-arm from DONE, adds ovr.
// Revision    : 1.0 - initial release
// ============================================================================
module tdc_multi_channel #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [NUM_CH-1:0] start,
    input  wire logic [NUM_CH-1:0] stop,
    tdc_multi_channel_if.slave     rd_if,
    output logic      [NUM_CH-1:0] valid,
    output logic      [NUM_CH-1:0] busy,
`ifdef TDC_AUTO_REARM_EN
    output logic      [NUM_CH-1:0] ovr,
`endif
    output logic      [NUM_CH-1:0] ovf
);
    localparam int              c_NBYTES   = CNT_W / 8;
    localparam logic [1:0]      c_IDLE     = 2'd0;
    localparam logic [1:0]      c_RUN      = 2'd1;
    localparam logic [1:0]      c_DONE     = 2'd2;
    localparam logic [CNT_W-1:0] c_ALL_ONES = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_SAT      = {{(CNT_W-1){1'b1}}, 1'b0};

    logic [CNT_W-1:0] w_result [NUM_CH];
    logic [7:0]       w_rd_sel;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_start_sync, r_stop_sync;
        logic                   r_start_prev, r_stop_prev;
        logic                   w_start_rise, w_stop_rise, w_ack, w_sat;
        logic [1:0]             r_state, w_state_nxt;
        logic [CNT_W-1:0]       r_count, r_result;
        logic                   r_ovf, w_busy, w_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_start_sync <= '0;
                r_stop_sync  <= '0;
                r_start_prev <= 1'b0;
                r_stop_prev  <= 1'b0;
            end else begin
                r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], start[g]};
                r_stop_sync  <= {r_stop_sync[SYNC_STAGES-2:0], stop[g]};
                r_start_prev <= r_start_sync[SYNC_STAGES-1];
                r_stop_prev  <= r_stop_sync[SYNC_STAGES-1];
            end
        end

        assign w_start_rise = r_start_sync[SYNC_STAGES-1] & ~r_start_prev;
        assign w_stop_rise  = r_stop_sync[SYNC_STAGES-1] & ~r_stop_prev;
        assign w_ack        = rd_if.rd_ack && (int'(rd_if.rd_ch) == g);
        assign w_sat        = (r_count == c_SAT);

        always_ff @(posedge clk) begin
            if (rst) r_state <= c_IDLE;
            else     r_state <= w_state_nxt;
        end

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                c_IDLE: if (w_start_rise) w_state_nxt = w_stop_rise ? c_DONE : c_RUN;
                c_RUN:  if (w_stop_rise || w_sat) w_state_nxt = c_DONE;
                c_DONE: begin
                    // An ack wins over a coincident start, which is then lost.
                    if (w_ack) w_state_nxt = c_IDLE;
`ifdef TDC_AUTO_REARM_EN
                    else if (w_start_rise && !w_stop_rise) w_state_nxt = c_RUN;
`endif
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end

        always_comb begin
            w_busy  = 1'b0;
            w_valid = 1'b0;
            case (r_state)
                c_RUN:   w_busy  = 1'b1;
                c_DONE:  w_valid = 1'b1;
                default: ;
            endcase
        end

`ifdef TDC_AUTO_REARM_EN
        logic r_ovr;
        assign ovr[g] = r_ovr;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                r_count  <= '0;
                r_result <= '0;
                r_ovf    <= 1'b0;
`ifdef TDC_AUTO_REARM_EN
                r_ovr    <= 1'b0;
`endif
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_count <= '0;
                        if (w_start_rise && w_stop_rise) r_result <= '0;
                    end
                    c_RUN: begin
                        r_count <= r_count + 1'b1;
                        if (w_sat) begin
                            r_result <= c_ALL_ONES;
                            r_ovf    <= 1'b1;
                        end else if (w_stop_rise) begin
                            r_result <= r_count + 1'b1;
                        end
                    end
                    c_DONE: begin
                        if (w_ack) begin
                            r_ovf <= 1'b0;
`ifdef TDC_AUTO_REARM_EN
                            r_ovr <= 1'b0;
                        end else if (w_start_rise) begin
                            r_count <= '0;
                            r_ovf   <= 1'b0;
                            r_ovr   <= 1'b1;
                            if (w_stop_rise) r_result <= '0;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end

        assign w_result[g] = r_result;
        assign busy[g]     = w_busy;
        assign valid[g]    = w_valid;
        assign ovf[g]      = r_ovf;
    end

    // Out-of-range channel or byte selects fall through to zero.
    always_comb begin
        w_rd_sel = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < c_NBYTES; b++) begin
                if ((int'(rd_if.rd_ch) == c) && (int'(rd_if.rd_byte) == b))
                    w_rd_sel = w_result[c][8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_if.rd_data <= 8'h00;
        else     rd_if.rd_data <= w_rd_sel;
    end
endmodule
`default_nettype wire

// File: tb/tb_tdc_multi_channel.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdc_multi_channel
// Description : Directed bench for tdc_multi_channel (2ch/16b and 3ch/8b).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_multi_channel;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start_a, stop_a, valid_a, busy_a, ovf_a;
    logic [2:0] start_b, stop_b, valid_b, busy_b, ovf_b;
`ifdef TDC_AUTO_REARM_EN
    logic [1:0] ovr_a;
    logic [2:0] ovr_b;
`endif
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tdc_multi_channel_if #(.NUM_CH(2), .CNT_W(16)) if_a ();
    tdc_multi_channel_if #(.NUM_CH(3), .CNT_W(8))  if_b ();

    tdc_multi_channel #(.NUM_CH(2), .CNT_W(16), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .rd_if(if_a.slave),
        .valid(valid_a), .busy(busy_a),
`ifdef TDC_AUTO_REARM_EN
        .ovr(ovr_a),
`endif
        .ovf(ovf_a));

    tdc_multi_channel #(.NUM_CH(3), .CNT_W(8), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .rd_if(if_b.slave),
        .valid(valid_b), .busy(busy_b),
`ifdef TDC_AUTO_REARM_EN
        .ovr(ovr_b),
`endif
        .ovf(ovf_b));

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic hit(input int s, input int c);
        return (s >= 0) && (c >= s) && (c < s + 2);
    endfunction

    // Two-cycle pad pulses at the given cycle offsets; -1 means no pulse.
    task automatic drive_a(input int s0, input int s0b, input int e0,
                           input int s1, input int e1, input int n);
        for (int c = 0; c < n; c++) begin
            start_a[0] = hit(s0, c) || hit(s0b, c);
            stop_a[0]  = hit(e0, c);
            start_a[1] = hit(s1, c);
            stop_a[1]  = hit(e1, c);
            tick(1);
        end
        start_a = '0;
        stop_a  = '0;
    endtask

    task automatic drive_b(input int s0, input int e0, input int n);
        for (int c = 0; c < n; c++) begin
            start_b[0] = hit(s0, c);
            stop_b[0]  = hit(e0, c);
            tick(1);
        end
        start_b = '0;
        stop_b  = '0;
    endtask

    task automatic read_a(input int ch, input int by, output logic [7:0] d);
        if_a.rd_ch   = 1'(ch);
        if_a.rd_byte = 1'(by);
        tick(1);
        d = if_a.rd_data;
    endtask

    task automatic read_b(input int ch, input int by, output logic [7:0] d);
        if_b.rd_ch   = 2'(ch);
        if_b.rd_byte = 1'(by);
        tick(1);
        d = if_b.rd_data;
    endtask

    task automatic ack_a(input int ch);
        if_a.rd_ch  = 1'(ch);
        if_a.rd_ack = 1'b1;
        tick(1);
        if_a.rd_ack = 1'b0;
    endtask

    task automatic ack_b(input int ch);
        if_b.rd_ch  = 2'(ch);
        if_b.rd_ack = 1'b1;
        tick(1);
        if_b.rd_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        vectors++; if ({valid_a, busy_a, ovf_a} !== 6'b0) begin miscompares++;
            $display("FAIL reset_a_flags: got %b expected 000000", {valid_a, busy_a, ovf_a}); end
        vectors++; if ({valid_b, busy_b, ovf_b} !== 9'b0) begin miscompares++;
            $display("FAIL reset_b_flags: got %b expected 000000000", {valid_b, busy_b, ovf_b}); end
        vectors++; if (if_a.rd_data !== 8'h00) begin miscompares++;
            $display("FAIL reset_a_rd_data: got %h expected 00", if_a.rd_data); end
        vectors++; if (if_b.rd_data !== 8'h00) begin miscompares++;
            $display("FAIL reset_b_rd_data: got %h expected 00", if_b.rd_data); end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        drive_a(0, -1, -1, -1, -1, 50);
        vectors++; if (busy_a !== 2'b01 || valid_a !== 2'b00) begin miscompares++;
            $display("FAIL basic_busy: got busy=%b valid=%b expected busy=01 valid=00", busy_a, valid_a); end
        drive_a(-1, -1, 50, -1, -1, 58);
        vectors++; if (valid_a !== 2'b01 || busy_a !== 2'b00) begin miscompares++;
            $display("FAIL basic_valid: got valid=%b busy=%b expected valid=01 busy=00", valid_a, busy_a); end
        read_a(0, 0, d);
        vectors++; if (d !== 8'h64) begin miscompares++;
            $display("FAIL basic_byte0: got %h expected 64", d); end
        read_a(0, 1, d);
        vectors++; if (d !== 8'h00) begin miscompares++;
            $display("FAIL basic_byte1: got %h expected 00", d); end
        ack_a(0);
        vectors++; if (valid_a !== 2'b00) begin miscompares++;
            $display("FAIL basic_ack: got valid=%b expected 00", valid_a); end
    endtask

    task automatic test_concurrent();
        logic [7:0] d;
        drive_a(5, -1, 42, 0, 1000, 1008);
        vectors++; if (valid_a !== 2'b11) begin miscompares++;
            $display("FAIL conc_valid: got %b expected 11", valid_a); end
        read_a(0, 0, d);
        vectors++; if (d !== 8'h25) begin miscompares++;
            $display("FAIL conc_ch0_b0: got %h expected 25", d); end
        read_a(0, 1, d);
        vectors++; if (d !== 8'h00) begin miscompares++;
            $display("FAIL conc_ch0_b1: got %h expected 00", d); end
        read_a(1, 0, d);
        vectors++; if (d !== 8'hE8) begin miscompares++;
            $display("FAIL conc_ch1_b0: got %h expected e8", d); end
        read_a(1, 1, d);
        vectors++; if (d !== 8'h03) begin miscompares++;
            $display("FAIL conc_ch1_b1: got %h expected 03", d); end
        ack_a(1);
        vectors++; if (valid_a !== 2'b01) begin miscompares++;
            $display("FAIL conc_ack1: got valid=%b expected 01", valid_a); end
        ack_a(0);
    endtask

    task automatic test_edges();
        logic [7:0] d;
        drive_a(0, -1, 0, -1, -1, 8);
        vectors++; if (valid_a !== 2'b01 || busy_a !== 2'b00) begin miscompares++;
            $display("FAIL simul_flags: got valid=%b busy=%b expected 01 00", valid_a, busy_a); end
        read_a(0, 0, d);
        vectors++; if (d !== 8'h00) begin miscompares++;
            $display("FAIL simul_result: got %h expected 00", d); end
        ack_a(0);
        drive_a(-1, -1, 0, -1, -1, 8);
        vectors++; if (valid_a !== 2'b00 || busy_a !== 2'b00) begin miscompares++;
            $display("FAIL stop_alone: got valid=%b busy=%b expected 00 00", valid_a, busy_a); end
        drive_a(0, 10, 30, -1, -1, 38);
        read_a(0, 0, d);
        vectors++; if (d !== 8'h1E || valid_a !== 2'b01) begin miscompares++;
            $display("FAIL second_start: got %h valid=%b expected 1e valid=01", d, valid_a); end
        ack_a(0);
    endtask

    task automatic test_rearm();
        logic [7:0] d;
        drive_a(-1, -1, -1, 0, 10, 16);
        drive_a(-1, -1, -1, 0, 20, 10);
`ifdef TDC_AUTO_REARM_EN
        vectors++; if (ovr_a !== 2'b10 || valid_a !== 2'b00 || busy_a !== 2'b10) begin miscompares++;
            $display("FAIL rearm_flags: got ovr=%b valid=%b busy=%b expected 10 00 10", ovr_a, valid_a, busy_a); end
        drive_a(-1, -1, -1, -1, 10, 16);
        read_a(1, 0, d);
        vectors++; if (d !== 8'h14 || valid_a !== 2'b10) begin miscompares++;
            $display("FAIL rearm_result: got %h valid=%b expected 14 10", d, valid_a); end
        ack_a(1);
        vectors++; if (ovr_a !== 2'b00) begin miscompares++;
            $display("FAIL rearm_ack_ovr: got %b expected 00", ovr_a); end
`else
        drive_a(-1, -1, -1, -1, 10, 16);
        read_a(1, 0, d);
        vectors++; if (d !== 8'h0A || valid_a !== 2'b10 || busy_a !== 2'b00) begin miscompares++;
            $display("FAIL done_ignores_start: got %h valid=%b busy=%b expected 0a 10 00", d, valid_a, busy_a); end
        ack_a(1);
`endif
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        drive_b(0, -1, 257);
        vectors++; if (valid_b !== 3'b000 || busy_b !== 3'b001) begin miscompares++;
            $display("FAIL ovf_before: got valid=%b busy=%b expected 000 001", valid_b, busy_b); end
        tick(1);
        vectors++; if (valid_b !== 3'b001 || ovf_b !== 3'b001 || busy_b !== 3'b000) begin miscompares++;
            $display("FAIL ovf_flags: got valid=%b ovf=%b busy=%b expected 001 001 000", valid_b, ovf_b, busy_b); end
        drive_b(-1, 0, 8);
        read_b(0, 0, d);
        vectors++; if (d !== 8'hFF || valid_b !== 3'b001) begin miscompares++;
            $display("FAIL ovf_result: got %h valid=%b expected ff 001", d, valid_b); end
        read_b(0, 1, d);
        vectors++; if (d !== 8'h00) begin miscompares++;
            $display("FAIL byte_range: got %h expected 00", d); end
        read_b(3, 0, d);
        vectors++; if (d !== 8'h00) begin miscompares++;
            $display("FAIL ch_range: got %h expected 00", d); end
        ack_b(0);
        vectors++; if (valid_b !== 3'b000 || ovf_b !== 3'b000) begin miscompares++;
            $display("FAIL ovf_ack: got valid=%b ovf=%b expected 000 000", valid_b, ovf_b); end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] d;
        drive_a(0, -1, -1, -1, -1, 53);
        vectors++; if (busy_a !== 2'b01) begin miscompares++;
            $display("FAIL midrun_busy: got %b expected 01", busy_a); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        vectors++; if (busy_a !== 2'b00 || valid_a !== 2'b00) begin miscompares++;
            $display("FAIL midrun_reset: got busy=%b valid=%b expected 00 00", busy_a, valid_a); end
        drive_a(0, -1, 12, -1, -1, 18);
        read_a(0, 0, d);
        vectors++; if (d !== 8'h0C || valid_a !== 2'b01) begin miscompares++;
            $display("FAIL after_reset_measure: got %h valid=%b expected 0c 01", d, valid_a); end
    endtask

    initial begin
        rst          = 1'b1;
        start_a      = '0;
        stop_a       = '0;
        start_b      = '0;
        stop_b       = '0;
        if_a.rd_ch   = '0;
        if_a.rd_byte = '0;
        if_a.rd_ack  = 1'b0;
        if_b.rd_ch   = '0;
        if_b.rd_byte = '0;
        if_b.rd_ack  = 1'b0;
        test_reset();
        test_basic();
        test_concurrent();
        test_edges();
        test_rearm();
        test_overflow();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
